// File: rtl/i2s_stereo_serializer.sv
// I2S transmitter: stereo pairs enter over valid/ready into a one-deep hold register and shift out MSB-first.
// Latency: MSB one bclk after each lrclk transition; in_ready is held low while the hold register is full.
module i2s_stereo_serializer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int MONO         = 0
) (
   input  logic                    bclk,
   input  logic                    reset,
   input  logic                    lrclk,
   input  logic [SAMPLE_WIDTH-1:0] in_left,
   input  logic [SAMPLE_WIDTH-1:0] in_right,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    data,
   output logic                    underrun
);

   localparam int CW = $clog2(SAMPLE_WIDTH) + 1;
   localparam logic [CW-1:0] CNT_DONE = CW'(SAMPLE_WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef struct packed {
      logic [SAMPLE_WIDTH-1:0] left;
      logic [SAMPLE_WIDTH-1:0] right;
   } pair_t;

   logic                    lrclk_d1_q, lrclk_d1_d;
   logic                    hold_full_q, hold_full_d;
   pair_t                   hold_q, hold_d;
   pair_t                   active_q, active_d;
   logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    data_q, data_d;
   logic                    underrun_q, underrun_d;

   logic                    left_start;
   logic                    right_start;
   logic                    accept;
   logic [SAMPLE_WIDTH-1:0] slot_word;

   assign in_ready = ~hold_full_q;
   assign data     = data_q;
   assign underrun = underrun_q;

   always_comb begin
      left_start  = lrclk_d1_q & ~lrclk;
      right_start = ~lrclk_d1_q & lrclk;
      accept      = in_valid & ~hold_full_q;

      lrclk_d1_d  = lrclk;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      active_d    = active_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      data_d      = 1'b0;
      underrun_d  = 1'b0;
      slot_word   = '0;

      if (accept) begin
         hold_d.left  = in_left;
         hold_d.right = in_right;
         hold_full_d  = 1'b1;
      end

      // A left start with nothing buffered sends silence for the whole frame.
      if (left_start) begin
         if (hold_full_q) begin
            active_d    = hold_q;
            hold_full_d = 1'b0;
         end else begin
            active_d   = '0;
            underrun_d = 1'b1;
         end
         slot_word = active_d.left;
      end else if (right_start) begin
         slot_word = (MONO != 0) ? active_q.left : active_q.right;
      end

      // Any slot edge restarts at the MSB, even if the previous word was cut short.
      if (left_start || right_start) begin
         data_d  = slot_word[SAMPLE_WIDTH-1];
         shift_d = {slot_word[SAMPLE_WIDTH-2:0], 1'b0};
         cnt_d   = CNT_ONE;
      end else if (cnt_q != CNT_DONE) begin
         data_d  = shift_q[SAMPLE_WIDTH-1];
         shift_d = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
         cnt_d   = cnt_q + CNT_ONE;
      end
   end

   always_ff @(negedge bclk or posedge reset) begin
      if (reset) begin
         lrclk_d1_q  <= 1'b0;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         active_q    <= '0;
         shift_q     <= '0;
         cnt_q       <= CNT_DONE;
         data_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         lrclk_d1_q  <= lrclk_d1_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         active_q    <= active_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_i2s_stereo_serializer.sv
// Bench for i2s_stereo_serializer: a 16-bit stereo instance and a 24-bit mono instance share all stimulus;
// each has its own expectation queue drained by a monitor on every falling bclk edge.
module tb_i2s_stereo_serializer;

   typedef struct packed {
      logic d;
      logic u;
      logic r;
   } exp_t;

   logic        bclk;
   logic        reset;
   logic        lrclk;
   logic [23:0] in_left;
   logic [23:0] in_right;
   logic        in_valid;
   logic        data0, und0, rdy0;
   logic        data1, und1, rdy1;

   exp_t q0[$];
   exp_t q1[$];
   int   cur;
   int   tests;
   int   fails;

   i2s_stereo_serializer #(.SAMPLE_WIDTH(16), .MONO(0)) dut0 (
      .bclk     (bclk),
      .reset    (reset),
      .lrclk    (lrclk),
      .in_left  (in_left[15:0]),
      .in_right (in_right[15:0]),
      .in_valid (in_valid),
      .in_ready (rdy0),
      .data     (data0),
      .underrun (und0)
   );

   i2s_stereo_serializer #(.SAMPLE_WIDTH(24), .MONO(1)) dut1 (
      .bclk     (bclk),
      .reset    (reset),
      .lrclk    (lrclk),
      .in_left  (in_left),
      .in_right (in_right),
      .in_valid (in_valid),
      .in_ready (rdy1),
      .data     (data1),
      .underrun (und1)
   );

   initial bclk = 1'b0;
   always #5 bclk = ~bclk;

   task automatic chk(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got %b, expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic push(input logic d, input logic u, input logic r);
      exp_t e;
      e.d = d;
      e.u = u;
      e.r = r;
      if (cur == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   task automatic cyc(input logic lr, input logic d, input logic u, input logic r);
      @(posedge bclk);
      lrclk = lr;
      push(d, u, r);
   endtask

   // One-cycle valid pulse into an empty hold register; no word is in flight.
   task automatic offer(input logic lr, input logic [23:0] l, input logic [23:0] r);
      @(posedge bclk);
      lrclk    = lr;
      in_valid = 1'b1;
      in_left  = l;
      in_right = r;
      push(1'b0, 1'b0, 1'b0);
      @(posedge bclk);
      in_valid = 1'b0;
      push(1'b0, 1'b0, 1'b0);
   endtask

   // A slot of 'half' bclks: first w bits of word MSB-first, then zero padding.
   task automatic slot(input logic lr, input int half, input logic [23:0] word, input int w,
                       input logic u, input logic r_e, input logic r_rest, input logic clr);
      for (int k = 0; k < half; k++) begin
         @(posedge bclk);
         lrclk = lr;
         if (clr && k == 2) in_valid = 1'b0;
         push((k < w) ? word[w-1-k] : 1'b0, (k == 0) ? u : 1'b0, (k == 0) ? r_e : r_rest);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge bclk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("s16_data", data0, e.d);
            chk("s16_underrun", und0, e.u);
            chk("s16_in_ready", rdy0, e.r);
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge bclk);
         #1;
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("m24_data", data1, e.d);
            chk("m24_underrun", und1, e.u);
            chk("m24_in_ready", rdy1, e.r);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog at t=%0t: got no end of stimulus, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests    = 0;
      fails    = 0;
      cur      = 0;
      reset    = 1'b1;
      lrclk    = 1'b0;
      in_valid = 1'b0;
      in_left  = '0;
      in_right = '0;

      // Reset state on both instances
      repeat (3) begin
         @(posedge bclk);
         cur = 0; push(1'b0, 1'b0, 1'b1);
         cur = 1; push(1'b0, 1'b0, 1'b1);
      end
      @(posedge bclk);
      reset = 1'b0;
      cur = 0; push(1'b0, 1'b0, 1'b1);
      cur = 1; push(1'b0, 1'b0, 1'b1);
      cur = 0;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);

      // T1: one stereo pair, 64-bclk frame
      offer(1'b0, 24'h00A5C3, 24'h001234);
      slot(1'b1, 32, 24'h0, 16, 1'b0, 1'b0, 1'b0, 1'b0);
      slot(1'b0, 32, 24'h00A5C3, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(1'b1, 32, 24'h001234, 16, 1'b0, 1'b1, 1'b1, 1'b0);

      // T2: two frames with nothing offered
      repeat (2) begin
         slot(1'b0, 32, 24'h0, 16, 1'b1, 1'b1, 1'b1, 1'b0);
         slot(1'b1, 32, 24'h0, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      end

      // T3: back-to-back pairs with in_valid held high
      @(posedge bclk);
      lrclk    = 1'b1;
      in_valid = 1'b1;
      in_left  = 24'h000001;
      in_right = 24'h008000;
      push(1'b0, 1'b0, 1'b0);
      @(posedge bclk);
      in_left  = 24'h007FFF;
      in_right = 24'h00FFFF;
      push(1'b0, 1'b0, 1'b0);
      slot(1'b0, 32, 24'h000001, 16, 1'b0, 1'b1, 1'b0, 1'b1);
      slot(1'b1, 32, 24'h008000, 16, 1'b0, 1'b0, 1'b0, 1'b0);
      slot(1'b0, 32, 24'h007FFF, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(1'b1, 32, 24'h00FFFF, 16, 1'b0, 1'b1, 1'b1, 1'b0);

      // T4: 8-bclk slots truncate each word
      offer(1'b1, 24'h00F0F0, 24'h008001);
      slot(1'b0, 8, 24'h00F0F0, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(1'b1, 8, 24'h008001, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(1'b0, 8, 24'h0, 16, 1'b1, 1'b1, 1'b1, 1'b0);
      slot(1'b1, 32, 24'h0, 16, 1'b0, 1'b1, 1'b1, 1'b0);

      // T6: reset in the middle of a left word with the hold register full
      offer(1'b1, 24'h00C3A5, 24'h000F0F);
      slot(1'b0, 3, 24'h00C3A5, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      @(posedge bclk);
      in_valid = 1'b1;
      in_left  = 24'h001111;
      in_right = 24'h002222;
      push(1'b0, 1'b0, 1'b0);
      @(posedge bclk);
      in_valid = 1'b0;
      push(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge bclk);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_left  = 24'h004444;
      in_right = 24'h005555;
      push(1'b0, 1'b0, 1'b1);
      #1;
      chk("reset_async_data", data0, 1'b0);
      chk("reset_async_in_ready", rdy0, 1'b1);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge bclk);
      reset    = 1'b0;
      in_valid = 1'b0;
      push(1'b0, 1'b0, 1'b1);
      slot(1'b1, 32, 24'h0, 16, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(1'b0, 32, 24'h0, 16, 1'b1, 1'b1, 1'b1, 1'b0);

      // T5: mono 24-bit instance sends the left sample in both slots
      cur = 1;
      offer(1'b0, 24'hC00001, 24'h555555);
      slot(1'b1, 32, 24'h0, 24, 1'b0, 1'b0, 1'b0, 1'b0);
      slot(1'b0, 32, 24'hC00001, 24, 1'b0, 1'b1, 1'b1, 1'b0);
      slot(1'b1, 32, 24'hC00001, 24, 1'b0, 1'b1, 1'b1, 1'b0);

      repeat (3) @(negedge bclk);
      #2;
      tests++;
      if (q0.size() + q1.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q0.size() + q1.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
